// File: rtl/dra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dra_pkg
// Description : Shared types and constants for the dual resource acquirer.
// Revision    : 1.0 - initial release
// ============================================================================
package dra_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQ_A   = 3'd1,
    S_ACQ_B   = 3'd2,
    S_HOLD    = 3'd3,
    S_DROP    = 3'd4,
    S_BACKOFF = 3'd5
  } state_e;

  localparam logic [7:0] RETRY_MAX = 8'd255;

  // Maximal-length Galois masks (right-shifting form), indexed by LFSR width.
  localparam logic [7:0] LFSR_TAPS [3:8] = '{8'h06, 8'h0C, 8'h14, 8'h30, 8'h60, 8'hB8};

endpackage
`default_nettype wire

// File: rtl/dual_resource_acquirer_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_resource_acquirer_if
// Description : Client, arbiter and status signals of the dual resource acquirer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_resource_acquirer_if;

  logic       start;
  logic       need_a;
  logic       need_b;
  logic       release_req;
  logic       gnt_a;
  logic       gnt_b;
  logic       req_a;
  logic       req_b;
  logic       busy;
  logic       hold;
  logic       done;
  logic       abort;
  logic       grant_lost;
  logic [7:0] retry_cnt;

  modport master (
    input  start, need_a, need_b, release_req, gnt_a, gnt_b,
    output req_a, req_b, busy, hold, done, abort, grant_lost, retry_cnt
  );

  modport slave (
    output start, need_a, need_b, release_req, gnt_a, gnt_b,
    input  req_a, req_b, busy, hold, done, abort, grant_lost, retry_cnt
  );

endinterface
`default_nettype wire

// File: rtl/dra_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : dra_lfsr
// Description : Galois LFSR supplying backoff lengths; never reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dra_lfsr #(
  parameter int W    = 3,
  parameter int SEED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] value
);
  import dra_pkg::*;

  localparam logic [W-1:0] c_taps = LFSR_TAPS[W][W-1:0];
  localparam logic [W-1:0] c_seed = SEED[W-1:0];

  logic [W-1:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= c_seed;
    end else if (step) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_taps : '0);
    end
  end

  assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/dual_resource_acquirer.sv
`default_nettype none
// ============================================================================
// Module      : dual_resource_acquirer
// Description : Acquires arbiters A then B, holds until release, and recovers
//               from deadlock/starvation with a watchdog and random backoff.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_resource_acquirer #(
  parameter int TIMEOUT   = 17,
  parameter int BACKOFF_W = 3,
  parameter int LFSR_SEED = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dual_resource_acquirer_if.master  bus
);
  import dra_pkg::*;

  localparam int                    c_wd_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0]     c_wd_last = c_wd_w'(TIMEOUT - 1);
  localparam logic [c_wd_w-1:0]     c_wd_one  = c_wd_w'(1);
  localparam logic [BACKOFF_W-1:0]  c_bo_one  = BACKOFF_W'(1);

  state_e                r_state, w_state_nxt;
  logic                  r_need_a, r_need_b, w_need_a_nxt, w_need_b_nxt;
  logic [c_wd_w-1:0]     r_wd, w_wd_nxt;
  logic [BACKOFF_W-1:0]  r_bo, w_bo_nxt, w_lfsr_val;
  logic [7:0]            r_retry, w_retry_nxt;
  logic                  w_lfsr_step, w_lost;
  logic                  r_req_a, r_req_b, r_busy, r_hold, r_done, r_abort, r_grant_lost;
  logic                  w_req_a_nxt, w_req_b_nxt;

  dra_lfsr #(.W(BACKOFF_W), .SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (w_lfsr_step),
    .value (w_lfsr_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_need_a     <= 1'b0;
      r_need_b     <= 1'b0;
      r_wd         <= '0;
      r_bo         <= '0;
      r_retry      <= '0;
      r_req_a      <= 1'b0;
      r_req_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_hold       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_grant_lost <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_need_a     <= w_need_a_nxt;
      r_need_b     <= w_need_b_nxt;
      r_wd         <= w_wd_nxt;
      r_bo         <= w_bo_nxt;
      r_retry      <= w_retry_nxt;
      r_req_a      <= w_req_a_nxt;
      r_req_b      <= w_req_b_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_hold       <= (w_state_nxt == S_HOLD);
      r_done       <= (w_state_nxt == S_HOLD) && (r_state != S_HOLD);
      r_abort      <= (w_state_nxt == S_DROP);
      r_grant_lost <= w_lost;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_need_a_nxt = r_need_a;
    w_need_b_nxt = r_need_b;
    w_wd_nxt     = r_wd;
    w_bo_nxt     = r_bo;
    w_retry_nxt  = r_retry;
    w_lfsr_step  = 1'b0;
    w_lost       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.need_a || bus.need_b)) begin
          w_need_a_nxt = bus.need_a;
          w_need_b_nxt = bus.need_b;
          w_retry_nxt  = '0;
          w_wd_nxt     = '0;
          if (bus.need_a) w_state_nxt = S_ACQ_A;
          else            w_state_nxt = S_ACQ_B;
        end
      end
      S_ACQ_A: begin
        // The watchdog keeps running into ACQ_B: one budget per attempt.
        if (bus.gnt_a) begin
          w_wd_nxt = r_wd + c_wd_one;
          if (r_need_b) w_state_nxt = S_ACQ_B;
          else          w_state_nxt = S_HOLD;
        end else if (r_wd >= c_wd_last) begin
          w_state_nxt = S_DROP;
        end else begin
          w_wd_nxt = r_wd + c_wd_one;
        end
      end
      S_ACQ_B: begin
        if (bus.gnt_b && (bus.gnt_a || !r_need_a)) begin
          w_state_nxt = S_HOLD;
        end else if (r_need_a && !bus.gnt_a) begin
          w_state_nxt = S_DROP;
          w_lost      = 1'b1;
        end else if (r_wd >= c_wd_last) begin
          w_state_nxt = S_DROP;
        end else begin
          w_wd_nxt = r_wd + c_wd_one;
        end
      end
      S_HOLD: begin
        if (bus.release_req) begin
          w_state_nxt = S_IDLE;
        end else if ((r_need_a && !bus.gnt_a) || (r_need_b && !bus.gnt_b)) begin
          w_state_nxt = S_DROP;
          w_lost      = 1'b1;
        end
      end
      S_DROP: begin
        w_bo_nxt    = w_lfsr_val;
        w_lfsr_step = 1'b1;
        w_state_nxt = S_BACKOFF;
      end
      S_BACKOFF: begin
        if (r_bo <= c_bo_one) begin
          w_wd_nxt = '0;
          if (r_need_a) w_state_nxt = S_ACQ_A;
          else          w_state_nxt = S_ACQ_B;
        end else begin
          w_bo_nxt = r_bo - c_bo_one;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if ((w_state_nxt == S_DROP) && (r_retry != RETRY_MAX)) w_retry_nxt = r_retry + 8'd1;

    w_req_a_nxt = (w_state_nxt == S_ACQ_A) ||
                  (((w_state_nxt == S_ACQ_B) || (w_state_nxt == S_HOLD)) && w_need_a_nxt);
    w_req_b_nxt = (w_state_nxt == S_ACQ_B) || ((w_state_nxt == S_HOLD) && w_need_b_nxt);
  end

  assign bus.req_a      = r_req_a;
  assign bus.req_b      = r_req_b;
  assign bus.busy       = r_busy;
  assign bus.hold       = r_hold;
  assign bus.done       = r_done;
  assign bus.abort      = r_abort;
  assign bus.grant_lost = r_grant_lost;
  assign bus.retry_cnt  = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_dual_resource_acquirer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_resource_acquirer
// Description : Directed bench with a behavioural reference model for the acquirer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_resource_acquirer;

  localparam int T = 17;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  dual_resource_acquirer_if bus();

  dual_resource_acquirer #(.TIMEOUT(T), .BACKOFF_W(3), .LFSR_SEED(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_abort_seen = 0;
  bit chk_en = 1'b0;
  int cnt, gap, k, ab0;

  // Arbiter emulation: mode 0 = grant after a_delay request cycles, 1 = never, 2 = always
  int   a_mode = 0, b_mode = 0, a_delay = 0, b_delay = 0;
  int   ra_cnt = 0, rb_cnt = 0;
  logic auto_a = 1'b0, auto_b = 1'b0;

  always @(negedge clk) begin
    ra_cnt = bus.req_a ? ra_cnt + 1 : 0;
    rb_cnt = bus.req_b ? rb_cnt + 1 : 0;
    auto_a = bus.req_a && (ra_cnt > a_delay);
    auto_b = bus.req_b && (rb_cnt > b_delay);
  end

  assign bus.gnt_a = (a_mode == 2) || ((a_mode == 0) && auto_a);
  assign bus.gnt_b = (b_mode == 2) || ((b_mode == 0) && auto_b);

  // Reference model: idle / acquiring / holding / pausing (drop + backoff)
  int m_mode = 0;
  bit m_na = 0, m_nb = 0, m_have_a = 0;
  int m_att = 0, m_pause = 0, m_aborts = 0, m_retries = 0;
  bit m_done = 0, m_abort = 0, m_gl = 0, m_give_up = 0, m_lost = 0;
  int bo_seq [7] = '{1, 6, 3, 7, 5, 4, 2};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_na = 0; m_nb = 0; m_have_a = 0; m_att = 0; m_pause = 0;
      m_aborts = 0; m_retries = 0; m_done = 0; m_abort = 0; m_gl = 0;
    end else begin
      m_done = 0; m_abort = 0; m_gl = 0; m_give_up = 0; m_lost = 0;
      case (m_mode)
        0: if (bus.start && (bus.need_a || bus.need_b)) begin
             m_na = bus.need_a; m_nb = bus.need_b; m_retries = 0;
             m_mode = 1; m_att = 0; m_have_a = !bus.need_a;
           end
        1: if (!m_have_a) begin
             if (bus.gnt_a) begin
               m_have_a = 1;
               if (!m_nb) begin m_mode = 2; m_done = 1; end
               else m_att++;
             end else if (m_att >= T - 1) m_give_up = 1;
             else m_att++;
           end else begin
             if (bus.gnt_b && (bus.gnt_a || !m_na)) begin m_mode = 2; m_done = 1; end
             else if (m_na && !bus.gnt_a) begin m_give_up = 1; m_lost = 1; end
             else if (m_att >= T - 1) m_give_up = 1;
             else m_att++;
           end
        2: if (bus.release_req) m_mode = 0;
           else if ((m_na && !bus.gnt_a) || (m_nb && !bus.gnt_b)) begin
             m_give_up = 1; m_lost = 1;
           end
        default: begin
          m_pause--;
          if (m_pause == 0) begin m_mode = 1; m_att = 0; m_have_a = !m_na; end
        end
      endcase
      if (m_give_up) begin
        m_mode = 3;
        m_pause = 1 + bo_seq[m_aborts % 7];
        m_aborts++;
        if (m_retries < 255) m_retries++;
        m_abort = 1;
        m_gl = m_lost;
      end
    end
  end

  function automatic logic [14:0] model_vec();
    logic ea, eb;
    ea = ((m_mode == 1) || (m_mode == 2)) && m_na;
    eb = m_nb && (((m_mode == 1) && m_have_a) || (m_mode == 2));
    return {ea, eb, m_mode != 0, m_mode == 2, m_done, m_abort, m_gl, 8'(m_retries)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {bus.req_a, bus.req_b, bus.busy, bus.hold, bus.done, bus.abort,
            bus.grant_lost, bus.retry_cnt};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL cycle_check t=%0t: dut=%b model=%b", $time, dut_vec(), model_vec());
      end
      if (bus.abort) n_abort_seen++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.hold;
      1:       return bus.req_b;
      default: return bus.retry_cnt == 8'd255;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string nm, output int waited);
    waited = 0;
    while ((sig(which) !== 1'b1) && (waited < budget)) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (sig(which) !== 1'b1) begin
      n_err++;
      $display("FAIL %s: not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic do_start(input logic a, input logic b);
    @(negedge clk);
    bus.start = 1'b1; bus.need_a = a; bus.need_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_release();
    @(negedge clk);
    bus.release_req = 1'b1;
    @(negedge clk);
    bus.release_req = 1'b0;
  endtask

  task automatic count_timeout(input string nm);
    cnt = 0;
    while (bus.req_a && (cnt < 100)) begin cnt++; @(negedge clk); end
    check({nm, "_req_a_cycles"}, cnt, 17);
    check({nm, "_abort"}, bus.abort, 1);
    check({nm, "_retry"}, bus.retry_cnt, 1);
    a_mode = 0;
    gap = 0;
    while (!bus.req_a && (gap < 100)) begin gap++; @(negedge clk); end
    check({nm, "_gap"}, gap, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.start = 1'b0; bus.need_a = 1'b0; bus.need_b = 1'b0; bus.release_req = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", dut_vec(), 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // start with no needs is ignored
    do_start(1'b0, 1'b0);
    check("no_need_busy", bus.busy, 0);

    // T1: normal acquisition of both
    a_mode = 0; b_mode = 0; a_delay = 2; b_delay = 1;
    do_start(1'b1, 1'b1);
    check("t1_req_a_first", bus.req_a, 1);
    check("t1_req_b_first", bus.req_b, 0);
    wait_for(0, 50, "t1_hold", k);
    check("t1_hold_latency", k, 5);
    check("t1_done", bus.done, 1);
    check("t1_retry", bus.retry_cnt, 0);
    do_release();
    check("t1_rel_reqs", {bus.req_a, bus.req_b}, 0);
    check("t1_rel_busy", bus.busy, 0);

    // T2: timeout on A, success on second attempt
    a_mode = 1; a_delay = 1;
    do_start(1'b1, 1'b0);
    count_timeout("t2");
    wait_for(0, 50, "t2_hold", k);
    check("t2_retry_at_hold", bus.retry_cnt, 1);
    do_release();

    // T4: grant arrives in the last watchdog cycle
    a_mode = 0; a_delay = 16;
    ab0 = n_abort_seen;
    do_start(1'b1, 1'b0);
    wait_for(0, 40, "t4_hold", k);
    check("t4_hold_latency", k, 17);
    check("t4_retry", bus.retry_cnt, 0);
    check("t4_no_abort", n_abort_seen - ab0, 0);
    do_release();

    // T5a: grant B lost while holding
    a_delay = 0; b_delay = 0;
    do_start(1'b1, 1'b1);
    wait_for(0, 20, "t5a_hold", k);
    b_mode = 1;
    @(negedge clk);
    check("t5a_grant_lost", bus.grant_lost, 1);
    check("t5a_abort", bus.abort, 1);
    check("t5a_reqs", {bus.req_a, bus.req_b}, 0);
    b_mode = 0;
    wait_for(0, 60, "t5a_rehold", k);
    do_release();

    // T5b: release and grant loss together
    do_start(1'b1, 1'b1);
    wait_for(0, 20, "t5b_hold", k);
    b_mode = 1; bus.release_req = 1'b1;
    @(negedge clk);
    bus.release_req = 1'b0;
    check("t5b_busy", bus.busy, 0);
    check("t5b_pulses", {bus.grant_lost, bus.abort}, 0);
    check("t5b_reqs", {bus.req_a, bus.req_b}, 0);
    b_mode = 0;

    // T3: B never granted, retry counter saturates
    b_mode = 1;
    do_start(1'b0, 1'b1);
    wait_for(2, 20000, "t3_saturate", k);
    ab0 = n_abort_seen;
    k = 0;
    while (((n_abort_seen - ab0) < 3) && (k < 200)) begin @(negedge clk); k++; end
    check("t3_extra_aborts", n_abort_seen - ab0, 3);
    check("t3_retry_sat", bus.retry_cnt, 255);
    b_mode = 0;
    wait_for(0, 60, "t3_hold", k);
    do_release();

    // T6: asynchronous reset in ACQ_B
    a_delay = 0; b_mode = 1;
    do_start(1'b1, 1'b1);
    wait_for(1, 20, "t6_acq_b", k);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", dut_vec(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; b_mode = 0; a_delay = 2; b_delay = 1;
    do_start(1'b1, 1'b1);
    wait_for(0, 50, "t6_hold", k);
    check("t6_hold_latency", k, 5);
    check("t6_retry", bus.retry_cnt, 0);
    do_release();
    a_mode = 1; a_delay = 1;
    do_start(1'b1, 1'b0);
    count_timeout("t6");
    wait_for(0, 50, "t6_rehold", k);
    do_release();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
